// File: rtl/line_buf_ctrl.sv
// Line-buffer sequencing controller: frame/line counting, overrun guard and
// PIPE_LAT-aligned window strobes. Border flags built only with LINE_BUF_CTRL_BORDER_EN.
//
//   state | meaning
//   IDLE  | after reset, waiting for the first vsync rising edge
//   FILL  | first two lines of a frame, loading the line buffers
//   RUN   | window valid, matrix strobes forwarded
//   DONE  | frame complete, input ignored until next vsync
module line_buf_ctrl #(
  parameter logic [12:0] IMG_HDISP = 13'd640,
  parameter logic [12:0] IMG_VDISP = 13'd480,
  parameter int          PIPE_LAT  = 3
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_href,
  input  logic        pre_frame_clken,
  output logic        line_clken,
  output logic        line_href,
  output logic        matrix_frame_vsync,
  output logic        matrix_frame_href,
  output logic        matrix_frame_clken,
  output logic        matrix_top_edge,
  output logic        matrix_bottom_edge,
  output logic        matrix_left_edge,
  output logic        matrix_right_edge,
  output logic [12:0] col_cnt,
  output logic [12:0] row_cnt,
  output logic        err_overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic              line_open_q, line_open_d;
  logic [12:0]       col_cnt_q, col_cnt_d;
  logic [12:0]       row_cnt_q, row_cnt_d;
  logic              err_q, err_d;
  logic              line_clken_q, line_clken_d;
  logic [PIPE_LAT:0] clken_pipe_q, clken_pipe_d;
  logic [PIPE_LAT-1:0] href_pipe_q, href_pipe_d;
  logic [PIPE_LAT-1:0] vsync_pipe_q, vsync_pipe_d;

  logic vsync_rise, active, line_ok, pix, in_range, run_clken, line_end;

  always_comb begin
    vsync_rise = pre_frame_vsync & ~vsync_q;
    active     = (state_q == FILL) || (state_q == RUN);
    // an href-high period that began before the current frame started is not a line
    line_ok    = line_open_q | ~href_q;
    pix        = pre_frame_clken & pre_frame_href & active & line_ok;
    in_range   = col_cnt_q < IMG_HDISP;
    line_end   = line_open_q & ~pre_frame_href;

    state_d      = state_q;
    vsync_d      = pre_frame_vsync;
    href_d       = pre_frame_href;
    line_open_d  = active & pre_frame_href & line_ok;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    err_d        = err_q;
    line_clken_d = pix & in_range;

    if (active) begin
      if (!pre_frame_href) begin
        col_cnt_d = '0;
      end else if (pix && (col_cnt_q != '1)) begin
        col_cnt_d = col_cnt_q + 13'd1;
      end
      if (pix && !in_range) begin
        err_d = 1'b1;
      end
      if (line_end) begin
        row_cnt_d = row_cnt_q + 13'd1;
        if ((state_q == FILL) && (row_cnt_d == 13'd2)) begin
          state_d = RUN;
        end else if ((state_q == RUN) && (row_cnt_d == IMG_VDISP)) begin
          state_d = DONE;
        end
      end
    end

    if (vsync_rise) begin
      state_d      = FILL;
      line_open_d  = 1'b0;
      col_cnt_d    = '0;
      row_cnt_d    = '0;
      err_d        = 1'b0;
      line_clken_d = 1'b0;
    end

    run_clken    = line_clken_d & (state_q == RUN);
    clken_pipe_d = {clken_pipe_q[PIPE_LAT-1:0], run_clken};
    if (vsync_rise) begin
      clken_pipe_d = '0;
    end

    href_pipe_d[0]  = pre_frame_href & (state_q == RUN);
    vsync_pipe_d[0] = pre_frame_vsync;
    for (int i = 1; i < PIPE_LAT; i++) begin
      href_pipe_d[i]  = href_pipe_q[i-1];
      vsync_pipe_d[i] = vsync_pipe_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      line_open_q  <= 1'b0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      err_q        <= 1'b0;
      line_clken_q <= 1'b0;
      clken_pipe_q <= '0;
      href_pipe_q  <= '0;
      vsync_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      line_open_q  <= line_open_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      err_q        <= err_d;
      line_clken_q <= line_clken_d;
      clken_pipe_q <= clken_pipe_d;
      href_pipe_q  <= href_pipe_d;
      vsync_pipe_q <= vsync_pipe_d;
    end
  end

`ifdef LINE_BUF_CTRL_BORDER_EN
  // flags {top, bottom, left, right} travel with the RUN pixel they describe
  logic [3:0] edge_pipe_q [PIPE_LAT+1];
  logic [3:0] edge_pipe_d [PIPE_LAT+1];

  always_comb begin
    edge_pipe_d[0] = run_clken ? {row_cnt_q == 13'd2,
                                  row_cnt_q == (IMG_VDISP - 13'd1),
                                  col_cnt_q == 13'd0,
                                  col_cnt_q == (IMG_HDISP - 13'd1)} : 4'b0000;
    for (int i = 1; i <= PIPE_LAT; i++) begin
      edge_pipe_d[i] = vsync_rise ? 4'b0000 : edge_pipe_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i <= PIPE_LAT; i++) begin
      if (!rst_n) edge_pipe_q[i] <= 4'b0000;
      else        edge_pipe_q[i] <= edge_pipe_d[i];
    end
  end

  assign matrix_top_edge    = edge_pipe_q[PIPE_LAT][3];
  assign matrix_bottom_edge = edge_pipe_q[PIPE_LAT][2];
  assign matrix_left_edge   = edge_pipe_q[PIPE_LAT][1];
  assign matrix_right_edge  = edge_pipe_q[PIPE_LAT][0];
`else
  assign matrix_top_edge    = 1'b0;
  assign matrix_bottom_edge = 1'b0;
  assign matrix_left_edge   = 1'b0;
  assign matrix_right_edge  = 1'b0;
`endif

  assign line_clken         = line_clken_q;
  assign line_href          = pre_frame_href;
  assign matrix_frame_clken = clken_pipe_q[PIPE_LAT];
  assign matrix_frame_href  = href_pipe_q[PIPE_LAT-1];
  assign matrix_frame_vsync = vsync_pipe_q[PIPE_LAT-1];
  assign col_cnt            = col_cnt_q;
  assign row_cnt            = row_cnt_q;
  assign err_overrun        = err_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl with an 8x4 frame and PIPE_LAT=3.
// Edge-flag expectations follow LINE_BUF_CTRL_BORDER_EN.
module tb_line_buf_ctrl;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        pre_frame_vsync, pre_frame_href, pre_frame_clken;
  logic        line_clken, line_href;
  logic        matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
  logic        matrix_top_edge, matrix_bottom_edge, matrix_left_edge, matrix_right_edge;
  logic [12:0] col_cnt, row_cnt;
  logic        err_overrun;

  int checks = 0;
  int errors = 0;

`ifdef LINE_BUF_CTRL_BORDER_EN
  localparam int EXP_TOP = 8, EXP_BOT = 8, EXP_LEFT = 2, EXP_RIGHT = 2;
`else
  localparam int EXP_TOP = 0, EXP_BOT = 0, EXP_LEFT = 0, EXP_RIGHT = 0;
`endif

  line_buf_ctrl #(.IMG_HDISP(13'd8), .IMG_VDISP(13'd4), .PIPE_LAT(3)) dut (
    .clock(clock), .rst_n(rst_n),
    .pre_frame_vsync(pre_frame_vsync), .pre_frame_href(pre_frame_href),
    .pre_frame_clken(pre_frame_clken),
    .line_clken(line_clken), .line_href(line_href),
    .matrix_frame_vsync(matrix_frame_vsync), .matrix_frame_href(matrix_frame_href),
    .matrix_frame_clken(matrix_frame_clken),
    .matrix_top_edge(matrix_top_edge), .matrix_bottom_edge(matrix_bottom_edge),
    .matrix_left_edge(matrix_left_edge), .matrix_right_edge(matrix_right_edge),
    .col_cnt(col_cnt), .row_cnt(row_cnt), .err_overrun(err_overrun)
  );

  always #5 clock = ~clock;

  // event counters and 3-deep histories sampled on the falling edge
  int n_lc = 0, n_mc = 0, n_mh = 0, n_mv = 0;
  int n_mis_c = 0, n_mis_h = 0, n_mis_v = 0;
  int n_top = 0, n_bot = 0, n_left = 0, n_right = 0, n_stray = 0;
  logic [2:0] lc_h = '0, hr_h = '0, vs_h = '0;

  always @(negedge clock) begin
    if (line_clken === 1'b1) n_lc++;
    if (matrix_frame_clken === 1'b1) begin
      n_mc++;
      if (!lc_h[2]) n_mis_c++;
    end
    if (matrix_frame_href === 1'b1) begin
      n_mh++;
      if (!hr_h[2]) n_mis_h++;
    end
    if (matrix_frame_vsync === 1'b1) begin
      n_mv++;
      if (!vs_h[2]) n_mis_v++;
    end
    if (matrix_top_edge === 1'b1) n_top++;
    if (matrix_bottom_edge === 1'b1) n_bot++;
    if (matrix_left_edge === 1'b1) n_left++;
    if (matrix_right_edge === 1'b1) n_right++;
    if ((matrix_top_edge === 1'b1 || matrix_bottom_edge === 1'b1 ||
         matrix_left_edge === 1'b1 || matrix_right_edge === 1'b1) &&
        matrix_frame_clken !== 1'b1) n_stray++;
    lc_h = {lc_h[1:0], line_clken === 1'b1};
    hr_h = {hr_h[1:0], pre_frame_href === 1'b1};
    vs_h = {vs_h[1:0], pre_frame_vsync === 1'b1};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic h, input logic c);
    pre_frame_vsync = v;
    pre_frame_href  = h;
    pre_frame_clken = c;
    @(posedge clock);
    #1;
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame_start();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("vsync_lat_early", matrix_frame_vsync, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("vsync_lat3", matrix_frame_vsync, 1);
    check("start_row", row_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic full_frame(input string tag);
    int s_lc, s_mc, s_mh, s_mv, s_mc_m, s_mh_m, s_mv_m;
    int s_top, s_bot, s_left, s_right, s_stray;
    s_lc = n_lc; s_mc = n_mc; s_mh = n_mh; s_mv = n_mv;
    s_mc_m = n_mis_c; s_mh_m = n_mis_h; s_mv_m = n_mis_v;
    s_top = n_top; s_bot = n_bot; s_left = n_left; s_right = n_right; s_stray = n_stray;
    frame_start();
    for (int l = 0; l < 4; l++) send_line(8);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    check({tag, "_mclken_cnt"}, n_mc - s_mc, 16);
    check({tag, "_mclken_lat"}, n_mis_c - s_mc_m, 0);
    check({tag, "_lclken_cnt"}, n_lc - s_lc, 32);
    check({tag, "_mhref_cnt"}, n_mh - s_mh, 16);
    check({tag, "_mhref_lat"}, n_mis_h - s_mh_m, 0);
    check({tag, "_mvsync_cnt"}, n_mv - s_mv, 2);
    check({tag, "_mvsync_lat"}, n_mis_v - s_mv_m, 0);
    check({tag, "_row_done"}, row_cnt, 4);
    check({tag, "_err"}, err_overrun, 0);
    check({tag, "_top"}, n_top - s_top, EXP_TOP);
    check({tag, "_bottom"}, n_bot - s_bot, EXP_BOT);
    check({tag, "_left"}, n_left - s_left, EXP_LEFT);
    check({tag, "_right"}, n_right - s_right, EXP_RIGHT);
    check({tag, "_edge_stray"}, n_stray - s_stray, 0);
    s_lc = n_lc;
    send_line(8);
    check({tag, "_done_ignore_lc"}, n_lc - s_lc, 0);
    check({tag, "_done_ignore_row"}, row_cnt, 4);
  endtask

  initial begin
    int s_lc, s_mc;
    rst_n = 1'b0;
    pre_frame_vsync = 1'b0; pre_frame_href = 1'b0; pre_frame_clken = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_line_clken", line_clken, 0);
    check("rst_mclken", matrix_frame_clken, 0);
    check("rst_mhref", matrix_frame_href, 0);
    check("rst_mvsync", matrix_frame_vsync, 0);
    check("rst_col", col_cnt, 0);
    check("rst_row", row_cnt, 0);
    check("rst_err", err_overrun, 0);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // lines before any vsync are ignored in IDLE
    s_lc = n_lc;
    send_line(8);
    check("idle_ignore_lc", n_lc - s_lc, 0);
    check("idle_ignore_row", row_cnt, 0);

    full_frame("frame1");

    // overrun: 10-pixel line with an 8-pixel limit
    frame_start();
    s_lc = n_lc;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      check($sformatf("ovr_lclken_px%0d", i), line_clken, (i < 8) ? 1 : 0);
      check($sformatf("ovr_err_px%0d", i), err_overrun, (i >= 8) ? 1 : 0);
      check($sformatf("ovr_col_px%0d", i), col_cnt, i + 1);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("ovr_lclken_cnt", n_lc - s_lc, 8);
    check("ovr_row", row_cnt, 1);
    check("ovr_col_clear", col_cnt, 0);
    check("ovr_err_hold", err_overrun, 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    send_line(3);
    check("ovr_err_sticky", err_overrun, 1);
    check("ovr_row2", row_cnt, 2);
    cyc(1'b1, 1'b0, 1'b0);
    check("ovr_err_vsync_clear", err_overrun, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // short line after a fresh vsync counts without error
    s_lc = n_lc;
    send_line(3);
    check("short_row", row_cnt, 1);
    check("short_err", err_overrun, 0);
    check("short_lclken_cnt", n_lc - s_lc, 3);

    // mid-frame resync during the first RUN line
    frame_start();
    send_line(8);
    send_line(8);
    repeat (4) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    check("resync_row", row_cnt, 0);
    check("resync_col", col_cnt, 0);
    s_mc = n_mc;
    s_lc = n_lc;
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    check("resync_partial_col", col_cnt, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    check("resync_partial_row", row_cnt, 0);
    send_line(8);
    send_line(8);
    check("resync_fill_row", row_cnt, 2);
    check("resync_fill_mclken", n_mc - s_mc, 0);
    check("resync_fill_lclken", n_lc - s_lc, 16);
    send_line(8);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    check("resync_run_mclken", n_mc - s_mc, 8);
    check("resync_run_row", row_cnt, 3);

    // one-cycle reset in the middle of a RUN line
    frame_start();
    send_line(8);
    send_line(8);
    repeat (4) cyc(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("mrst_line_clken", line_clken, 0);
    check("mrst_line_href", line_href, 0);
    check("mrst_mclken", matrix_frame_clken, 0);
    check("mrst_mhref", matrix_frame_href, 0);
    check("mrst_mvsync", matrix_frame_vsync, 0);
    check("mrst_edges", {matrix_top_edge, matrix_bottom_edge, matrix_left_edge, matrix_right_edge}, 0);
    check("mrst_col", col_cnt, 0);
    check("mrst_row", row_cnt, 0);
    check("mrst_err", err_overrun, 0);
    s_lc = n_lc;
    s_mc = n_mc;
    send_line(8);
    send_line(8);
    check("mrst_idle_lc", n_lc - s_lc, 0);
    check("mrst_idle_mc", n_mc - s_mc, 0);
    check("mrst_idle_row", row_cnt, 0);

    full_frame("frame2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
